mastermind_scorer: RTL and testbench
====================================

Name: mastermind_scorer

Overview:
- Scoring engine for the Mastermind game, on the consuming side of the controller's `compare` request.
- Takes the stored secret code and the latest 4-peg guess and produces black (right colour, right place) and white (right colour, wrong place) peg counts.
- Tracks the turn count, win and game-over status.
- Sits between the control FSM and the HEX display driver, and talks to the control FSM through a start/valid/ack handshake.

Parameters:
- PEGS, 4, number of pegs per code/guess.
- COLOR_BITS, 3, bits per peg colour (NUM_COLORS = 2**COLOR_BITS = 8).
- MAX_TURNS, 10, guesses allowed before game over.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  asynchronous active-low reset.
- new_game  in  1  synchronous clear: aborts any scoring, resets turns, win and game_over.
- start  in  1  request to score; sampled only in IDLE.
- code  in  PEGS*COLOR_BITS  secret code. Peg i occupies [COLOR_BITS*i +: COLOR_BITS]; peg 0 is the first-loaded peg.
- guess  in  PEGS*COLOR_BITS  current guess, same packing as code.
- ack  in  1  consumer has taken the result.
- busy  out  1  scoring in progress (EXACT or COLOR state).
- valid  out  1  result available (DONE state).
- black  out  clog2(PEGS+1)  exact-match count.
- white  out  clog2(PEGS+1)  colour-only match count.
- win  out  1  black == PEGS on the last result; sticky until new_game.
- turns  out  clog2(MAX_TURNS+1)  number of guesses scored.
- game_over  out  1  win, or turns == MAX_TURNS; sticky until new_game.

Behaviour:
- Reset (resetn low, asynchronous):
  - state IDLE.
  - All outputs 0.
  - Internal counts and captured operands 0.
- new_game high at an edge:
  - Same values as reset, applied synchronously.
  - Has priority over every other input.
- IDLE:
  - start=1 and game_over=0 at an edge: capture code and guess into internal registers, clear black, white and the per-colour counters, index=0, go to EXACT.
  - start while game_over=1 is ignored.
  - code/guess changing after the capture edge has no effect on the result.
- EXACT (PEGS cycles, index 0..PEGS-1, one peg per cycle):
  - If code peg == guess peg: black += 1.
  - Otherwise: cc[code peg] += 1 and cg[guess peg] += 1.
  - After the last peg: index=0, go to COLOR.
- COLOR (NUM_COLORS cycles, index c = 0..NUM_COLORS-1):
  - white += min(cc[c], cg[c]).
  - After the last colour: go to DONE, and in the same edge:
    - turns += 1 (saturating at MAX_TURNS);
    - win = (black == PEGS);
    - game_over = win or turns reaching MAX_TURNS.
- DONE:
  - valid=1; black and white held stable.
  - ack=1 at an edge: go to IDLE, valid drops the next cycle.
  - black and white keep their values in IDLE until the next start capture.
- Latency: valid rises exactly PEGS + NUM_COLORS edges after the start-capture edge (12 with defaults).
- busy=1 in EXACT and COLOR only.
- start during busy or valid is ignored.
- start and ack high together in DONE: ack is honoured and start is ignored; a new start must be seen in IDLE.
- Counter widths: cc/cg entries are clog2(PEGS+1) bits and never exceed PEGS. By construction black + white <= PEGS.
- Asserting resetn low mid-scoring discards the operation immediately.
- The FSM encoding is a localparam; no latches; default next_state = IDLE.

Decomposition:
- Package mastermind_pkg:
  - PEGS, COLOR_BITS, NUM_COLORS, MAX_TURNS;
  - state localparams IDLE/EXACT/COLOR/DONE;
  - peg-extraction function.
- The controller and datapath share this package.
- One sub-module: mastermind_color_hist, holding the NUM_COLORS counter pair (cc, cg) with clear, increment-by-index and read-by-index.
- The scorer FSM instantiates mastermind_color_hist.

Test Plan:
- Reset:
  - Drive resetn low mid-scoring.
  - All outputs read 0 immediately (asynchronously); after release, state is IDLE and busy=0.
- Exact match:
  - code=12'h8D1 (pegs 1,2,3,4), guess=12'h8D1, start.
  - valid 12 cycles later; black=4, white=0, win=1, game_over=1, turns=1.
  - A further start is ignored until new_game.
- All colours present, none in place:
  - code=12'h8D1, guess=12'h70A (pegs 2,1,4,3).
  - black=0, white=4, win=0.
- Duplicate colours:
  - code=12'h489 (pegs 1,1,2,2), guess=12'h251 (pegs 1,2,1,1).
  - black=1, white=2.
- Handshake:
  - Hold ack low for 5 cycles in DONE: valid and results remain stable.
  - Assert start and ack together: FSM returns to IDLE with busy=0.
  - Raise start one cycle later: a new score begins.
- Turn limit:
  - Score 10 non-winning guesses (code=12'h8D1, guess=12'h000).
  - After the 10th: turns=10, game_over=1, win=0.
  - An 11th start is ignored.
  - new_game clears turns to 0 and game_over to 0.

Source files
------------

// File: rtl/mastermind_pkg.sv
// Shared constants, state encoding and peg helper for the Mastermind scorer.
package mastermind_pkg;

  localparam int PEGS       = 4;
  localparam int COLOR_BITS = 3;
  localparam int NUM_COLORS = 2 ** COLOR_BITS;
  localparam int MAX_TURNS  = 10;

  localparam int CODE_W = PEGS * COLOR_BITS;
  localparam int CNT_W  = $clog2(PEGS + 1);
  localparam int TURN_W = $clog2(MAX_TURNS + 1);
  localparam int PEG_W  = $clog2(PEGS);
  // The shared index walks both pegs and colours, so it is sized for the larger range.
  localparam int IDX_W  = (NUM_COLORS > PEGS) ? COLOR_BITS : PEG_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXACT = 2'd1,
    COLOR = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [COLOR_BITS-1:0] get_peg(input logic [CODE_W-1:0] vec,
                                                    input logic [PEG_W-1:0]  idx);
    return vec[COLOR_BITS*idx +: COLOR_BITS];
  endfunction

endpackage

// File: rtl/mastermind_scorer_if.sv
// Request/result bundle between the control FSM and the scorer.
interface mastermind_scorer_if;
  import mastermind_pkg::*;

  logic              new_game;
  logic              start;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] guess;
  logic              ack;
  logic              busy;
  logic              valid;
  logic [CNT_W-1:0]  black;
  logic [CNT_W-1:0]  white;
  logic              win;
  logic [TURN_W-1:0] turns;
  logic              game_over;

  modport master (
    output new_game, start, code, guess, ack,
    input  busy, valid, black, white, win, turns, game_over
  );

  modport slave (
    input  new_game, start, code, guess, ack,
    output busy, valid, black, white, win, turns, game_over
  );

endinterface

// File: rtl/mastermind_color_hist.sv
// Per-colour counters of unmatched code pegs (cc) and guess pegs (cg).
module mastermind_color_hist
  import mastermind_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  inc,
  input  logic [COLOR_BITS-1:0] inc_code_idx,
  input  logic [COLOR_BITS-1:0] inc_guess_idx,
  input  logic [COLOR_BITS-1:0] rd_idx,
  output logic [CNT_W-1:0]      rd_cc,
  output logic [CNT_W-1:0]      rd_cg
);

  logic [CNT_W-1:0] cc [NUM_COLORS];
  logic [CNT_W-1:0] cg [NUM_COLORS];

  // At most PEGS increments land between clears, so the counters cannot wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_COLORS; i++) begin
        cc[i] <= '0;
        cg[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < NUM_COLORS; i++) begin
        cc[i] <= '0;
        cg[i] <= '0;
      end
    end else if (inc) begin
      cc[inc_code_idx]  <= cc[inc_code_idx] + 1'b1;
      cg[inc_guess_idx] <= cg[inc_guess_idx] + 1'b1;
    end
  end

  assign rd_cc = cc[rd_idx];
  assign rd_cg = cg[rd_idx];

endmodule

// File: rtl/mastermind_scorer.sv
// Scorer FSM: exact pass over pegs, colour pass over the histogram, then hold the result.
module mastermind_scorer
  import mastermind_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  mastermind_scorer_if.slave  bus
);

  state_t            state;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] guess_q;
  logic [IDX_W-1:0]  idx;
  logic              busy;
  logic              valid;
  logic [CNT_W-1:0]  black;
  logic [CNT_W-1:0]  white;
  logic              win;
  logic [TURN_W-1:0] turns;
  logic              game_over;

  logic                  capture;
  logic [COLOR_BITS-1:0] code_peg;
  logic [COLOR_BITS-1:0] guess_peg;
  logic                  peg_match;
  logic [CNT_W-1:0]      rd_cc;
  logic [CNT_W-1:0]      rd_cg;
  logic [CNT_W-1:0]      min_cnt;
  logic [TURN_W-1:0]     turns_next;
  logic                  win_next;

  assign capture    = (state == IDLE) && bus.start && !game_over;
  assign code_peg   = get_peg(code_q, idx[PEG_W-1:0]);
  assign guess_peg  = get_peg(guess_q, idx[PEG_W-1:0]);
  assign peg_match  = (code_peg == guess_peg);
  assign min_cnt    = (rd_cc < rd_cg) ? rd_cc : rd_cg;
  assign turns_next = (turns == TURN_W'(MAX_TURNS)) ? turns : turns + 1'b1;
  assign win_next   = (black == CNT_W'(PEGS));

  mastermind_color_hist u_hist (
    .clk           (clk),
    .resetn        (resetn),
    .clear         (bus.new_game || capture),
    .inc           ((state == EXACT) && !peg_match && !bus.new_game),
    .inc_code_idx  (code_peg),
    .inc_guess_idx (guess_peg),
    .rd_idx        (idx[COLOR_BITS-1:0]),
    .rd_cc         (rd_cc),
    .rd_cg         (rd_cg)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      code_q    <= '0;
      guess_q   <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      black     <= '0;
      white     <= '0;
      win       <= 1'b0;
      turns     <= '0;
      game_over <= 1'b0;
    end else if (bus.new_game) begin
      state     <= IDLE;
      code_q    <= '0;
      guess_q   <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      black     <= '0;
      white     <= '0;
      win       <= 1'b0;
      turns     <= '0;
      game_over <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            code_q  <= bus.code;
            guess_q <= bus.guess;
            black   <= '0;
            white   <= '0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= EXACT;
          end
        end
        EXACT: begin
          if (peg_match) black <= black + 1'b1;
          if (idx == IDX_W'(PEGS - 1)) begin
            idx   <= '0;
            state <= COLOR;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        COLOR: begin
          white <= white + min_cnt;
          if (idx == IDX_W'(NUM_COLORS - 1)) begin
            busy      <= 1'b0;
            valid     <= 1'b1;
            turns     <= turns_next;
            win       <= win_next;
            game_over <= win_next || (turns_next == TURN_W'(MAX_TURNS));
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.ack) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.valid     = valid;
  assign bus.black     = black;
  assign bus.white     = white;
  assign bus.win       = win;
  assign bus.turns     = turns;
  assign bus.game_over = game_over;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Directed bench for mastermind_scorer: vector table plus handshake, reset and turn-limit sequences.
module tb_mastermind_scorer;
  import mastermind_pkg::*;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  mastermind_scorer_if bus ();

  mastermind_scorer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] code;
    logic [11:0] guess;
    int          exp_black;
    int          exp_white;
    int          exp_win;
  } vec_t;

  vec_t vecs [6];

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
  endtask

  // Start a score, scramble the inputs after capture, and count edges until valid.
  task automatic apply_stimulus(input logic [11:0] c, input logic [11:0] g, output int lat);
    @(negedge clk);
    bus.code  = c;
    bus.guess = g;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.code  = 12'(~c);
    bus.guess = 12'(g ^ 12'hA5A);
    lat = 0;
    while (!bus.valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack_result();
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
  endtask

  initial begin
    int lat;
    int hb;
    int hw;
    checks = 0;
    errors = 0;
    bus.new_game = 1'b0;
    bus.start    = 1'b0;
    bus.code     = '0;
    bus.guess    = '0;
    bus.ack      = 1'b0;

    vecs[0] = '{12'h8D1, 12'h8D1, 4, 0, 1};
    vecs[1] = '{12'h8D1, 12'h70A, 0, 4, 0};
    vecs[2] = '{12'h489, 12'h251, 1, 2, 0};
    vecs[3] = '{12'h8D1, 12'h711, 2, 2, 0};
    vecs[4] = '{12'h8D1, 12'hFFF, 0, 0, 0};
    vecs[5] = '{12'h000, 12'h000, 4, 0, 1};

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_output("reset_busy", int'(bus.busy), 0);
    check_output("reset_valid", int'(bus.valid), 0);
    check_output("reset_turns", int'(bus.turns), 0);
    check_output("reset_game_over", int'(bus.game_over), 0);

    for (int i = 0; i < 6; i++) begin
      pulse_new_game();
      apply_stimulus(vecs[i].code, vecs[i].guess, lat);
      check_output($sformatf("v%0d_latency", i), lat, 12);
      check_output($sformatf("v%0d_black", i), int'(bus.black), vecs[i].exp_black);
      check_output($sformatf("v%0d_white", i), int'(bus.white), vecs[i].exp_white);
      check_output($sformatf("v%0d_win", i), int'(bus.win), vecs[i].exp_win);
      check_output($sformatf("v%0d_turns", i), int'(bus.turns), 1);
      check_output($sformatf("v%0d_game_over", i), int'(bus.game_over), vecs[i].exp_win);
      ack_result();
      check_output($sformatf("v%0d_valid_drop", i), int'(bus.valid), 0);
      check_output($sformatf("v%0d_black_held", i), int'(bus.black), vecs[i].exp_black);
    end

    // Game already won by the last vector: a further start must be ignored.
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    check_output("won_start_busy", int'(bus.busy), 0);
    check_output("won_start_turns", int'(bus.turns), 1);

    // Handshake: hold result without ack, then start+ack together.
    pulse_new_game();
    apply_stimulus(12'h489, 12'h251, lat);
    check_output("hs_latency", lat, 12);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_output($sformatf("hs_hold_valid%0d", k), int'(bus.valid), 1);
      check_output($sformatf("hs_hold_black%0d", k), int'(bus.black), 1);
      check_output($sformatf("hs_hold_white%0d", k), int'(bus.white), 2);
    end
    bus.start = 1'b1;
    bus.ack   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    check_output("hs_both_valid", int'(bus.valid), 0);
    check_output("hs_both_busy", int'(bus.busy), 0);
    @(negedge clk);
    check_output("hs_idle_busy", int'(bus.busy), 0);
    apply_stimulus(12'h8D1, 12'h70A, lat);
    check_output("hs_restart_latency", lat, 12);
    check_output("hs_restart_white", int'(bus.white), 4);
    check_output("hs_restart_turns", int'(bus.turns), 2);
    ack_result();

    // Asynchronous reset in the middle of scoring.
    @(negedge clk);
    bus.code  = 12'h8D1;
    bus.guess = 12'h8D1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check_output("mid_busy_before", int'(bus.busy), 1);
    #2;
    resetn = 1'b0;
    #1;
    check_output("mid_rst_busy", int'(bus.busy), 0);
    check_output("mid_rst_turns", int'(bus.turns), 0);
    check_output("mid_rst_white", int'(bus.white), 0);
    check_output("mid_rst_black", int'(bus.black), 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (14) @(negedge clk);
    check_output("post_rst_busy", int'(bus.busy), 0);
    check_output("post_rst_valid", int'(bus.valid), 0);

    // Turn limit with non-winning guesses.
    pulse_new_game();
    for (int t = 1; t <= 10; t++) begin
      apply_stimulus(12'h8D1, 12'h000, lat);
      hb = int'(bus.black);
      hw = int'(bus.white);
      check_output($sformatf("lim%0d_latency", t), lat, 12);
      check_output($sformatf("lim%0d_turns", t), int'(bus.turns), t);
      check_output($sformatf("lim%0d_game_over", t), int'(bus.game_over), (t == 10) ? 1 : 0);
      check_output($sformatf("lim%0d_score", t), hb * 8 + hw, 0);
      ack_result();
    end
    check_output("lim_win", int'(bus.win), 0);
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    check_output("lim_11th_busy", int'(bus.busy), 0);
    check_output("lim_11th_turns", int'(bus.turns), 10);
    pulse_new_game();
    check_output("ng_turns", int'(bus.turns), 0);
    check_output("ng_game_over", int'(bus.game_over), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
